// File: rtl/rfphoenix_issue_queue.sv
// In-order issue queue between decode and the scoreboard, with a one-cycle RAW interlock and rollback flush.
// Define RFPHOENIX_ISSQ_BYPASS_EN to let an instruction pass straight through an empty queue.
package rfPhoenixPkg;
    typedef struct packed {
        logic       vec;
        logic [5:0] num;
    } regspec_t;

    typedef struct packed {
        logic        v;
        logic [31:0] ins;
        logic        hasRa;
        logic        hasRb;
        logic        hasRc;
        logic        hasRm;
        logic        hasRt;
        regspec_t    Ra;
        regspec_t    Rb;
        regspec_t    Rc;
        regspec_t    Rm;
        regspec_t    Rt;
    } decode_bus_t;
endpackage

module rfphoenix_issue_queue
    import rfPhoenixPkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNTW  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     dec_v,
    input  decode_bus_t              dec_db,
    output logic                     dec_rdy,
    input  logic                     can_issue,
    output logic                     will_issue,
    output decode_bus_t              iss_db,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNTW-1:0]          stall_cnt
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    decode_bus_t    mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic           last_v;
    regspec_t       last_Rt;

    logic           empty;
    logic           full;
    logic           dep;
    logic           push;
    logic           pop;
    logic           stall_inc;
    decode_bus_t    head;
`ifdef RFPHOENIX_ISSQ_BYPASS_EN
    logic           byp;
`endif

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    always_comb begin
        head   = mem[rd_ptr];
        head.v = ~empty;
        iss_db = head;
`ifdef RFPHOENIX_ISSQ_BYPASS_EN
        byp = empty & dec_v & ~flush;
        if (byp) begin
            iss_db   = dec_db;
            iss_db.v = 1'b1;
        end
`endif
        // Interlock against the instruction issued last cycle, whose busy bit is not yet visible
        dep = last_v & ((iss_db.hasRa & (iss_db.Ra == last_Rt)) |
                        (iss_db.hasRb & (iss_db.Rb == last_Rt)) |
                        (iss_db.hasRc & (iss_db.Rc == last_Rt)) |
                        (iss_db.hasRm & (iss_db.Rm == last_Rt)));
        will_issue = iss_db.v & can_issue & ~dep & ~flush;
        dec_rdy    = ~full & ~flush;
`ifdef RFPHOENIX_ISSQ_BYPASS_EN
        push = dec_v & dec_rdy & ~(byp & will_issue);
`else
        push = dec_v & dec_rdy;
`endif
        pop       = will_issue & ~empty;
        stall_inc = ~empty & ~will_issue & ~flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            last_v    <= 1'b0;
            last_Rt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
                last_v <= 1'b0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                count  <= count + CW'(push) - CW'(pop);
                last_v <= will_issue & iss_db.hasRt & (iss_db.Rt != '0);
            end
            last_Rt <= iss_db.Rt;
            if (stall_inc && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= dec_db;
    end
endmodule

// File: tb/tb_rfphoenix_issue_queue.sv
// Directed self-checking bench for rfphoenix_issue_queue (DEPTH=4); bypass expectations follow RFPHOENIX_ISSQ_BYPASS_EN.
module tb_rfphoenix_issue_queue;
    import rfPhoenixPkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          dec_v;
    decode_bus_t   dec_db;
    logic          dec_rdy;
    logic          can_issue;
    logic          will_issue;
    decode_bus_t   iss_db;
    logic          flush;
    logic [2:0]    count;
    logic [31:0]   stall_cnt;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    rfphoenix_issue_queue #(.DEPTH(4), .CNTW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .dec_v     (dec_v),
        .dec_db    (dec_db),
        .dec_rdy   (dec_rdy),
        .can_issue (can_issue),
        .will_issue(will_issue),
        .iss_db    (iss_db),
        .flush     (flush),
        .count     (count),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic regspec_t r(input logic vec, input int unsigned n);
        regspec_t x;
        x.vec = vec;
        x.num = 6'(n);
        return x;
    endfunction

    function automatic decode_bus_t mk(input int unsigned tag, input logic has_rt, input regspec_t rt,
                                       input logic has_ra, input regspec_t ra);
        decode_bus_t d;
        d       = '0;
        d.v     = 1'b1;
        d.ins   = 32'(tag);
        d.hasRt = has_rt;
        d.Rt    = rt;
        d.hasRa = has_ra;
        d.Ra    = ra;
        return d;
    endfunction

    function automatic decode_bus_t plain(input int unsigned tag);
        return mk(tag, 1'b0, '0, 1'b0, '0);
    endfunction

    task automatic drive(input logic v, input decode_bus_t db, input logic ci, input logic fl);
        dec_v     = v;
        dec_db    = db;
        can_issue = ci;
        flush     = fl;
        #1;
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned exp_cnt [5];
        exp_cnt = '{4, 3, 3, 2, 1};

        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        check("rst_dec_rdy", 64'(dec_rdy), 64'd1);
        check("rst_will_issue", 64'(will_issue), 64'd0);
        check("rst_iss_v", 64'(iss_db.v), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_stall", 64'(stall_cnt), 64'd0);

        // Fill with issue blocked
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, plain(i), 1'b0, 1'b0);
            check("fill_rdy", 64'(dec_rdy), 64'd1);
            cyc();
        end
        drive(1'b1, plain(5), 1'b0, 1'b0);
        check("full_count", 64'(count), 64'd4);
        check("full_rdy", 64'(dec_rdy), 64'd0);
        check("full_stall", 64'(stall_cnt), 64'd3);
        check("full_head", 64'(iss_db.ins), 64'd1);
        cyc();
        check("full_hold", 64'(count), 64'd4);
        check("full_stall2", 64'(stall_cnt), 64'd4);

        // Drain in order; tag 5 enters once a slot frees
        for (int i = 0; i < 5; i++) begin
            drive(i < 2, plain(5), 1'b1, 1'b0);
            check("drain_head", 64'(iss_db.ins), 64'(i + 1));
            check("drain_issue", 64'(will_issue), 64'd1);
            check("drain_count", 64'(count), 64'(exp_cnt[i]));
            if (i < 2)
                check("drain_rdy", 64'(dec_rdy), (i == 0) ? 64'd0 : 64'd1);
            cyc();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        check("drained_v", 64'(iss_db.v), 64'd0);
        check("drained_issue", 64'(will_issue), 64'd0);
        check("drained_stall", 64'(stall_cnt), 64'd4);

        // Dependent pair through r5: exactly one bubble
        drive(1'b1, mk(10, 1'b1, r(1'b0, 5), 1'b0, '0), 1'b0, 1'b0);
        cyc();
        drive(1'b1, mk(11, 1'b0, '0, 1'b1, r(1'b0, 5)), 1'b0, 1'b0);
        cyc();
        drive(1'b0, '0, 1'b1, 1'b0);
        check("dep_a_issue", 64'(will_issue), 64'd1);
        cyc();
        check("dep_bubble", 64'(will_issue), 64'd0);
        check("dep_bubble_head", 64'(iss_db.ins), 64'd11);
        cyc();
        check("dep_b_issue", 64'(will_issue), 64'd1);
        cyc();
        check("dep_stall", 64'(stall_cnt), 64'd6);

        // Through r0: no bubble
        drive(1'b1, mk(12, 1'b1, r(1'b0, 0), 1'b0, '0), 1'b0, 1'b0);
        cyc();
        drive(1'b1, mk(13, 1'b0, '0, 1'b1, r(1'b0, 0)), 1'b0, 1'b0);
        cyc();
        drive(1'b0, '0, 1'b1, 1'b0);
        check("r0_c_issue", 64'(will_issue), 64'd1);
        cyc();
        check("r0_d_issue", 64'(will_issue), 64'd1);
        check("r0_d_head", 64'(iss_db.ins), 64'd13);
        cyc();

        // Vector v5 vs scalar r5 differ only in vec bit: no bubble
        drive(1'b1, mk(14, 1'b1, r(1'b1, 5), 1'b0, '0), 1'b0, 1'b0);
        cyc();
        drive(1'b1, mk(15, 1'b0, '0, 1'b1, r(1'b0, 5)), 1'b0, 1'b0);
        cyc();
        drive(1'b0, '0, 1'b1, 1'b0);
        check("vec_e_issue", 64'(will_issue), 64'd1);
        cyc();
        check("vec_f_issue", 64'(will_issue), 64'd1);
        cyc();
        check("vec_stall", 64'(stall_cnt), 64'd8);

        // Flush at count 3 with a same-cycle push offered
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, plain(20 + i), 1'b0, 1'b0);
            cyc();
        end
        drive(1'b1, plain(23), 1'b1, 1'b1);
        check("fl_count3", 64'(count), 64'd3);
        check("fl_rdy", 64'(dec_rdy), 64'd0);
        check("fl_issue", 64'(will_issue), 64'd0);
        cyc();
        drive(1'b0, '0, 1'b1, 1'b0);
        check("fl_count", 64'(count), 64'd0);
        check("fl_v", 64'(iss_db.v), 64'd0);
        check("fl_stall", 64'(stall_cnt), 64'd10);
        drive(1'b1, plain(30), 1'b0, 1'b0);
        cyc();
        drive(1'b0, '0, 1'b1, 1'b0);
        check("fl_after_count", 64'(count), 64'd1);
        check("fl_after_head", 64'(iss_db.ins), 64'd30);
        cyc();

        // Steady push+pop at count 2 across pointer wrap
        drive(1'b1, plain(40), 1'b0, 1'b0);
        cyc();
        drive(1'b1, plain(41), 1'b0, 1'b0);
        cyc();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, plain(42 + i), 1'b1, 1'b0);
            check("wrap_head", 64'(iss_db.ins), 64'(40 + i));
            check("wrap_count", 64'(count), 64'd2);
            check("wrap_issue", 64'(will_issue), 64'd1);
            cyc();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            check("wrap_tail", 64'(iss_db.ins), 64'(50 + i));
            cyc();
        end
        check("wrap_empty", 64'(count), 64'd0);
        check("wrap_stall", 64'(stall_cnt), 64'd11);

        // Empty queue, instruction offered with issue allowed
        drive(1'b1, plain(60), 1'b1, 1'b0);
`ifdef RFPHOENIX_ISSQ_BYPASS_EN
        check("byp_issue", 64'(will_issue), 64'd1);
        check("byp_head", 64'(iss_db.ins), 64'd60);
        cyc();
        drive(1'b0, '0, 1'b1, 1'b0);
        check("byp_count", 64'(count), 64'd0);
`else
        check("lat_issue0", 64'(will_issue), 64'd0);
        check("lat_v0", 64'(iss_db.v), 64'd0);
        cyc();
        drive(1'b0, '0, 1'b1, 1'b0);
        check("lat_issue1", 64'(will_issue), 64'd1);
        check("lat_head", 64'(iss_db.ins), 64'd60);
        cyc();
        check("lat_count", 64'(count), 64'd0);
`endif
        check("end_stall", 64'(stall_cnt), 64'd11);

        // Mid-operation reset discards entries and clears the counter
        drive(1'b1, plain(70), 1'b0, 1'b0);
        cyc();
        cyc();
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        cyc();
        rst = 1'b0;
        #1;
        check("mrst_count", 64'(count), 64'd0);
        check("mrst_v", 64'(iss_db.v), 64'd0);
        check("mrst_stall", 64'(stall_cnt), 64'd0);
        check("mrst_rdy", 64'(dec_rdy), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/rfphoenix_issue_queue.md
Name: rfphoenix_issue_queue

Overview:
- Small in-order FIFO of decoded instructions between the decode stage and the scoreboard/issue point.
- Decouples decode from issue stalls and presents the queue head to the scoreboard as its decode bus.
- Issues the head when the scoreboard grants it and raises will_issue back to the scoreboard.
- Interlocks back-to-back dependent instructions during the one cycle before scoreboard busy bits update; flushes on rollback.

Parameters:
- DEPTH, 4, number of queue entries; power of two, 2..16.
- CNTW, 32, width of the stall performance counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- dec_v  input  1  decode stage offers an instruction.
- dec_db  input  decode_bus_t  decoded instruction (rfPhoenixPkg).
- dec_rdy  output  1  queue can accept an instruction this cycle.
- can_issue  input  1  scoreboard: head sources not busy.
- will_issue  output  1  head issues this cycle.
- iss_db  output  decode_bus_t  queue head; iss_db.v=0 when empty.
- flush  input  1  rollback: discard all queued entries.
- count  output  $clog2(DEPTH)+1  current occupancy.
- stall_cnt  output  CNTW  cycles head valid but not issued.

Behaviour:
- Storage: DEPTH-entry circular buffer with rd_ptr, wr_ptr ($clog2(DEPTH) bits, wrap modulo DEPTH) and count.
- Reset (rst=1 at clk edge):
  - rd_ptr, wr_ptr, count, last_v, last_Rt, stall_cnt <= 0.
  - Outputs after reset: dec_rdy=1, will_issue=0, iss_db.v=0, count=0, stall_cnt=0.
  - Reset mid-operation discards all entries; entry contents are don't-care.
- dec_rdy = (count != DEPTH) & ~flush. Combinational; a full queue does not accept even when popping in the same cycle.
- Push when dec_v & dec_rdy: entry[wr_ptr] <= dec_db, wr_ptr++.
- Head: iss_db = entry[rd_ptr] with iss_db.v forced to (count != 0).
- Interlock (dep):
  - last_v/last_Rt are registered from the previous cycle's issue. last_v=1 only if that instruction had hasRt and Rt != 'd0.
  - dep = last_v & ((hasRa & Ra==last_Rt) | (hasRb & Rb==last_Rt) | (hasRc & Rc==last_Rt) | (hasRm & Rm==last_Rt)), evaluated on the head.
  - Full regspec compare, including the vec bit.
- Issue: will_issue = (count != 0) & can_issue & ~dep & ~flush. Combinational.
- Pop when will_issue: rd_ptr++.
- count update: count <= count + push - pop; simultaneous push and pop leaves count unchanged.
- last_v <= will_issue & iss_db.hasRt & (iss_db.Rt != 0); last_Rt <= iss_db.Rt.
- Flush: rd_ptr, wr_ptr, count <= 0; last_v <= 0. The same-cycle push is ignored (dec_rdy=0) and will_issue=0.
- Latency: an instruction pushed in cycle N is at the head and issuable in cycle N+1 at the earliest.
- stall_cnt: increments when (count != 0) & ~will_issue & ~flush; saturates at all-ones; cleared only by rst.
- Ordering: strictly FIFO; no reordering or entry skipping.

Optional Feature:
- Macro: RFPHOENIX_ISSQ_BYPASS_EN.
- Enabled: when count==0 and dec_v & ~flush, iss_db = dec_db.
  - If can_issue & ~dep, will_issue=1 and the instruction issues in the same cycle without being written (no push, count unchanged).
  - Otherwise it is pushed normally.
  - dep and last_Rt are evaluated on dec_db in this case.
- Disabled: minimum one-cycle latency; iss_db.v=0 whenever count==0.

Test Plan:
- Reset then 4 back-to-back pushes with can_issue=0 -> count=4, dec_rdy=0; 5th dec_v not accepted; stall_cnt increments from the cycle after the first push.
- Queue full, can_issue=1, dec_v=1 held -> one pop per cycle; push resumes the cycle after count becomes 3; issue order matches push order (tags 1,2,3,4,5).
- Issue instruction with Rt=r5, next head with Ra=r5, can_issue=1 -> will_issue=0 for exactly 1 cycle, then 1. Same sequence with Rt=r0 -> no bubble.
- Queue at count=3 with flush=1 and dec_v=1 -> next cycle count=0, iss_db.v=0, will_issue=0 during the flush cycle, pushed entry absent.
- Simultaneous push and pop at count=2 for 10 cycles -> count stays 2; wr_ptr/rd_ptr wrap past DEPTH-1 with correct order.
- With RFPHOENIX_ISSQ_BYPASS_EN, empty queue, dec_v=1, can_issue=1 -> will_issue=1 the same cycle, count stays 0. Without the macro -> will_issue=1 one cycle later.
